// File: rtl/cpu_clk_ctrl.sv
// cpu_clk_ctrl: run/step/halt controller that emits a single-cycle CPU clock enable.
// Optional tick-count breakpoint is built only when CPU_CLK_BKPT_EN is defined.
module cpu_clk_ctrl #(
  parameter logic [31:0] DIV_FAST = 32'd8,
  parameter logic [31:0] DIV_SLOW = 32'd33554432
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        run_en,
  input  logic        sel_slow,
  input  logic        step_req,
  input  logic        halt_req,
  input  logic        bkpt_en,
  input  logic [31:0] bkpt_val,
  output logic        cpu_ce,
  output logic [31:0] tick_cnt,
  output logic        halt_ack,
  output logic        bkpt_hit,
  output logic [1:0]  state
);
  localparam logic [1:0] S_HALT = 2'b00;
  localparam logic [1:0] S_RUN  = 2'b01;
  localparam logic [1:0] S_STEP = 2'b10;
  logic [1:0]  r_state, w_state_nx;
  logic [31:0] r_pre, w_pre_nx;
  logic [31:0] r_per, w_per_nx;
  logic [31:0] r_tick;
  logic        r_step_q, r_ce, r_ack, r_bkpt;
  logic        w_ce_nx, w_bkpt_nx;
  logic        w_edge, w_start, w_stop, w_term, w_bkpt_trip;
  logic [31:0] w_per_sel;
  assign w_edge    = step_req & ~r_step_q;
  assign w_start   = run_en & ~halt_req;
  assign w_stop    = ~run_en | halt_req;
  assign w_term    = r_pre == r_per - 32'd1;
  assign w_per_sel = sel_slow ? DIV_SLOW : DIV_FAST;
`ifdef CPU_CLK_BKPT_EN
  assign w_bkpt_trip = bkpt_en & (r_tick + 32'd1 == bkpt_val);
`else
  logic w_unused_bkpt;
  assign w_unused_bkpt = ^{bkpt_en, bkpt_val};
  assign w_bkpt_trip   = 1'b0;
`endif
  // Next-state decode: stop requests beat a coinciding terminal count, run beats a step edge
  always_comb begin
    w_state_nx = r_state;
    w_pre_nx   = r_pre;
    w_per_nx   = r_per;
    w_ce_nx    = 1'b0;
    w_bkpt_nx  = r_bkpt;
    if (r_state == S_HALT) begin
      if (w_start) begin
        w_state_nx = S_RUN;
        w_pre_nx   = 32'd0;
        w_per_nx   = w_per_sel;
        w_bkpt_nx  = 1'b0;
      end else if (w_edge) begin
        w_state_nx = S_STEP;
      end
    end else if (r_state == S_RUN) begin
      if (w_stop) begin
        w_state_nx = S_HALT;
        w_pre_nx   = 32'd0;
      end else if (w_term) begin
        w_pre_nx = 32'd0;
        w_ce_nx  = 1'b1;
        w_per_nx = w_per_sel;
        if (w_bkpt_trip) begin
          w_state_nx = S_HALT;
          w_bkpt_nx  = 1'b1;
        end
      end else begin
        w_pre_nx = r_pre + 32'd1;
      end
    end else if (r_state == S_STEP) begin
      w_state_nx = S_HALT;
      w_ce_nx    = 1'b1;
    end else begin
      w_state_nx = S_HALT;
    end
  end
  // State, prescaler, pulse and counter registers with asynchronous clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_HALT;
      r_pre    <= 32'd0;
      r_per    <= DIV_FAST;
      r_tick   <= 32'd0;
      r_step_q <= 1'b0;
      r_ce     <= 1'b0;
      r_ack    <= 1'b1;
      r_bkpt   <= 1'b0;
    end else begin
      r_state  <= w_state_nx;
      r_pre    <= w_pre_nx;
      r_per    <= w_per_nx;
      r_tick   <= r_tick + {31'd0, w_ce_nx};
      r_step_q <= step_req;
      r_ce     <= w_ce_nx;
      r_ack    <= w_state_nx == S_HALT;
      r_bkpt   <= w_bkpt_nx;
    end
  end
  assign cpu_ce   = r_ce;
  assign tick_cnt = r_tick;
  assign halt_ack = r_ack;
  assign bkpt_hit = r_bkpt;
  assign state    = r_state;
endmodule

// File: tb/tb_cpu_clk_ctrl.sv
// tb_cpu_clk_ctrl: directed scoreboard bench for cpu_clk_ctrl (DIV_FAST=8, DIV_SLOW=20)
module tb_cpu_clk_ctrl;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic        run_en = 1'b0, sel_slow = 1'b0, step_req = 1'b0, halt_req = 1'b0, bkpt_en = 1'b0;
  logic [31:0] bkpt_val = 32'd0;
  logic        cpu_ce, halt_ack, bkpt_hit;
  logic [31:0] tick_cnt;
  logic [1:0]  state;
  typedef struct { int cyc; logic [31:0] tick; } pulse_t;
  pulse_t      exp_q[$];
  int          cyc = 0, vecs = 0, errs = 0;
  logic [31:0] exp_tick = 32'd0;
  always #5 clk = ~clk;
  cpu_clk_ctrl #(.DIV_FAST(32'd8), .DIV_SLOW(32'd20)) dut (
    .clk(clk), .rst_n(rst_n), .run_en(run_en), .sel_slow(sel_slow),
    .step_req(step_req), .halt_req(halt_req), .bkpt_en(bkpt_en), .bkpt_val(bkpt_val),
    .cpu_ce(cpu_ce), .tick_cnt(tick_cnt), .halt_ack(halt_ack), .bkpt_hit(bkpt_hit),
    .state(state)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask
  task automatic expect_pulse(input int at);
    exp_tick = exp_tick + 32'd1;
    exp_q.push_back('{at, exp_tick});
  endtask
  task automatic tick();
    pulse_t p;
    logic   exp_ce;
    @(posedge clk);
    #1;
    cyc++;
    exp_ce = exp_q.size() != 0 && exp_q[0].cyc == cyc;
    chk("cpu_ce", {31'd0, cpu_ce}, {31'd0, exp_ce});
    if (exp_ce) begin
      p = exp_q.pop_front();
      chk("tick_at_pulse", tick_cnt, p.tick);
    end
  endtask
  task automatic do_step();
    expect_pulse(cyc + 2);
    step_req = 1'b1;
    tick();
    chk("step_state", {30'd0, state}, 32'd2);
    step_req = 1'b0;
    tick();
    chk("step_return", {30'd0, state}, 32'd0);
    tick();
    chk("step_tick", tick_cnt, exp_tick);
  endtask
  initial begin
    int c0, c1, c2, c3, c4;
    #12;
    chk("rst_state", {30'd0, state}, 32'd0);
    chk("rst_ack", {31'd0, halt_ack}, 32'd1);
    chk("rst_ce", {31'd0, cpu_ce}, 32'd0);
    chk("rst_tick", tick_cnt, 32'd0);
    chk("rst_bkpt", {31'd0, bkpt_hit}, 32'd0);
    rst_n = 1'b1;
    tick();
    tick();
    chk("idle_halt", {30'd0, state}, 32'd0);
    run_en = 1'b1;
    tick();
    c0 = cyc;
    chk("run_state", {30'd0, state}, 32'd1);
    chk("run_ack", {31'd0, halt_ack}, 32'd0);
    for (int k = 1; k <= 5; k++) expect_pulse(c0 + 8 * k);
    repeat (40) tick();
    chk("fast_tick5", tick_cnt, 32'd5);
    repeat (3) tick();
    sel_slow = 1'b1;
    expect_pulse(c0 + 48);
    expect_pulse(c0 + 68);
    repeat (7) tick();
    sel_slow = 1'b0;
    while (cyc < c0 + 75) tick();
    halt_req = 1'b1;
    tick();
    chk("halt_prio_state", {30'd0, state}, 32'd0);
    chk("halt_prio_ack", {31'd0, halt_ack}, 32'd1);
    chk("halt_prio_tick", tick_cnt, 32'd7);
    repeat (3) tick();
    chk("halt_over_run", {30'd0, state}, 32'd0);
    expect_pulse(cyc + 2);
    step_req = 1'b1;
    tick();
    chk("hold_step_state", {30'd0, state}, 32'd2);
    chk("hold_step_ack", {31'd0, halt_ack}, 32'd0);
    repeat (9) tick();
    step_req = 1'b0;
    tick();
    chk("hold_step_tick", tick_cnt, 32'd8);
    repeat (3) do_step();
    chk("toggle_tick", tick_cnt, 32'd11);
    halt_req = 1'b0;
    tick();
    c1 = cyc;
    chk("rerun_state", {30'd0, state}, 32'd1);
    expect_pulse(c1 + 8);
    tick();
    tick();
    step_req = 1'b1;
    tick();
    tick();
    step_req = 1'b0;
    while (cyc < c1 + 15) tick();
    run_en = 1'b0;
    tick();
    chk("stop_state", {30'd0, state}, 32'd0);
    chk("stop_ack", {31'd0, halt_ack}, 32'd1);
    chk("stop_tick", tick_cnt, 32'd12);
    run_en = 1'b1;
    step_req = 1'b1;
    tick();
    c2 = cyc;
    chk("run_beats_step", {30'd0, state}, 32'd1);
    expect_pulse(c2 + 8);
    while (cyc < c2 + 8) tick();
    halt_req = 1'b1;
    tick();
    chk("halt_after_pulse", {30'd0, state}, 32'd0);
    halt_req = 1'b0;
    run_en = 1'b0;
    step_req = 1'b0;
    tick();
`ifdef CPU_CLK_BKPT_EN
    bkpt_en = 1'b1;
    bkpt_val = exp_tick + 32'd3;
    run_en = 1'b1;
    tick();
    c3 = cyc;
    for (int k = 1; k <= 3; k++) expect_pulse(c3 + 8 * k);
    while (cyc < c3 + 24) tick();
    chk("bkpt_state", {30'd0, state}, 32'd0);
    chk("bkpt_ack", {31'd0, halt_ack}, 32'd1);
    chk("bkpt_hit", {31'd0, bkpt_hit}, 32'd1);
    tick();
    chk("bkpt_rerun_state", {30'd0, state}, 32'd1);
    chk("bkpt_rerun_clear", {31'd0, bkpt_hit}, 32'd0);
    run_en = 1'b0;
    tick();
    chk("bkpt_stop", {30'd0, state}, 32'd0);
    force dut.r_tick = 32'hFFFF_FFFF;
    #1;
    release dut.r_tick;
    exp_tick = 32'hFFFF_FFFF;
    do_step();
    chk("wrap_tick", tick_cnt, 32'd0);
`else
    bkpt_en = 1'b1;
    bkpt_val = exp_tick + 32'd1;
    run_en = 1'b1;
    tick();
    c3 = cyc;
    expect_pulse(c3 + 8);
    while (cyc < c3 + 8) tick();
    chk("nobkpt_state", {30'd0, state}, 32'd1);
    chk("nobkpt_hit", {31'd0, bkpt_hit}, 32'd0);
    run_en = 1'b0;
    tick();
`endif
    run_en = 1'b1;
    tick();
    c4 = cyc;
    expect_pulse(c4 + 8);
    while (cyc < c4 + 8) tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_ce", {31'd0, cpu_ce}, 32'd0);
    chk("async_rst_tick", tick_cnt, 32'd0);
    chk("async_rst_state", {30'd0, state}, 32'd0);
    chk("async_rst_ack", {31'd0, halt_ack}, 32'd1);
    exp_tick = 32'd0;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    c4 = cyc;
    chk("post_rst_run", {30'd0, state}, 32'd1);
    expect_pulse(c4 + 8);
    while (cyc < c4 + 8) tick();
    run_en = 1'b0;
    tick();
    chk("final_tick", tick_cnt, 32'd1);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
